cp0_ctrl: RTL and testbench

//  Parametrised coprocessor-0 for the pipelined MIPS core; sits beside the M stage.

---
 rtl/cp0_pkg.sv | 35 +++
 rtl/cp0_ctrl_if.sv | 29 ++
 rtl/cp0_timer.sv | 55 +++++
 rtl/cp0_ctrl.sv | 140 ++++++++++++++
 tb/tb_cp0_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 slice: register addresses, SR/Cause bit
// positions and the exception codes the pipeline can present.
package cp0_pkg;

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_SR       = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;
    localparam logic [4:0] ADDR_PRID     = 5'd15;

    localparam int SR_IE          = 0;
    localparam int SR_EXL         = 1;
    localparam int SR_IM_LSB      = 10;
    localparam int CAUSE_EXC_LSB  = 2;
    localparam int CAUSE_IPSW_LSB = 8;
    localparam int CAUSE_IP_LSB   = 10;
    localparam int CAUSE_TI       = 30;
    localparam int CAUSE_BD       = 31;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // Address-error exceptions are the only ones that latch BadVAddr.
    function automatic logic isAddrError(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_ctrl_if.sv
// Pipeline <-> CP0 bundle: mtc0/mfc0 access, victim-instruction info and the
// flush/redirect signals returned to the M stage.
interface cp0_ctrl_if #(parameter int NUM_HWINT = 6);

    logic                 en;
    logic [4:0]           CP0Addr;
    logic [31:0]          CP0In;
    logic [31:0]          CP0Out;
    logic [31:0]          VPC;
    logic                 BDin;
    logic [4:0]           ExcCodeIn;
    logic [31:0]          BadVAddrIn;
    logic [NUM_HWINT-1:0] HWInt;
    logic                 EXLClr;
    logic [31:0]          EPCOut;
    logic                 Req;
    logic                 TimerIrq;

    modport master (
        output en, CP0Addr, CP0In, VPC, BDin, ExcCodeIn, BadVAddrIn, HWInt, EXLClr,
        input  CP0Out, EPCOut, Req, TimerIrq
    );

    modport slave (
        input  en, CP0Addr, CP0In, VPC, BDin, ExcCodeIn, BadVAddrIn, HWInt, EXLClr,
        output CP0Out, EPCOut, Req, TimerIrq
    );

endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: a prescaled free-running Count and a sticky match flag TI
// that only a Compare write clears.
module cp0_timer #(
    parameter int COUNT_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        countWe,
    input  logic        compareWe,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam logic [4:0] PRE_LAST = 5'(COUNT_DIV - 1);

    logic [4:0] prescale;
    logic       tick;

    assign tick = (prescale == PRE_LAST);

    // A Count write restarts the prescaler so the new value holds a full period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale <= 5'd0;
            count    <= 32'd0;
        end else if (countWe) begin
            prescale <= 5'd0;
            count    <= wdata;
        end else if (tick) begin
            prescale <= 5'd0;
            count    <= count + 32'd1;
        end else begin
            prescale <= prescale + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            compare <= 32'hFFFF_FFFF;
            ti      <= 1'b0;
        end else begin
            if (compareWe) begin
                compare <= wdata;
            end
            if (compareWe) begin
                ti <= 1'b0;
            end else if (count == compare) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_ctrl.sv
// Coprocessor 0 beside the M stage: SR/Cause/EPC/BadVAddr/PRId, interrupt and
// exception arbitration, and the Count/Compare timer.
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter int          NUM_HWINT = 6,
    parameter bit          TIMER_EN  = 1'b1,
    parameter int          COUNT_DIV = 1,
    parameter logic [31:0] PRID_VAL  = 32'h0000_4C01
) (
    input  logic        clk,
    input  logic        reset,
    cp0_ctrl_if.slave   bus
);

    logic [31:0]          sr;
    logic [31:0]          epc;
    logic [31:0]          badVAddr;
    logic [31:0]          count;
    logic [31:0]          compare;
    logic                 ti;
    logic                 causeBd;
    logic [4:0]           causeExc;
    logic [1:0]           causeIpSw;
    logic [NUM_HWINT-1:0] causeIpHw;

    logic [NUM_HWINT-1:0] ipEff;
    logic                 exl;
    logic                 intReq;
    logic                 excReq;
    logic                 req;
    logic                 mtc0;
    logic [31:0]          epcNext;
    logic [31:0]          causeVal;
    logic [31:0]          readData;

    // The timer shares the top hardware line so it can be masked like any other source.
    always_comb begin
        ipEff = bus.HWInt;
        if (TIMER_EN) begin
            ipEff[NUM_HWINT-1] = bus.HWInt[NUM_HWINT-1] | ti;
        end
    end

    assign exl     = sr[SR_EXL];
    assign intReq  = (|(ipEff & sr[SR_IM_LSB +: NUM_HWINT])) & sr[SR_IE] & ~exl;
    assign excReq  = (bus.ExcCodeIn != EXC_INT) & ~exl;
    assign req     = intReq | excReq;
    assign mtc0    = bus.en & ~req;
    assign epcNext = req ? (bus.BDin ? bus.VPC - 32'd4 : bus.VPC) : epc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= 32'd0;
        end else if (req) begin
            sr[SR_EXL] <= 1'b1;
        end else begin
            if (mtc0 && bus.CP0Addr == ADDR_SR) begin
                sr <= bus.CP0In;
            end
            if (bus.EXLClr) begin
                sr[SR_EXL] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            causeBd   <= 1'b0;
            causeExc  <= 5'd0;
            causeIpSw <= 2'd0;
            causeIpHw <= '0;
        end else begin
            causeIpHw <= ipEff;
            if (req) begin
                causeBd  <= bus.BDin;
                causeExc <= intReq ? 5'(EXC_INT) : bus.ExcCodeIn;
            end else if (mtc0 && bus.CP0Addr == ADDR_CAUSE) begin
                causeBd   <= bus.CP0In[CAUSE_BD];
                causeExc  <= bus.CP0In[CAUSE_EXC_LSB +: 5];
                causeIpSw <= bus.CP0In[CAUSE_IPSW_LSB +: 2];
            end
        end
    end

    // BadVAddr is architecturally read-only; only a taken address error loads it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc      <= 32'd0;
            badVAddr <= 32'd0;
        end else if (req) begin
            epc <= epcNext;
            if (!intReq && isAddrError(bus.ExcCodeIn)) begin
                badVAddr <= bus.BadVAddrIn;
            end
        end else if (mtc0 && bus.CP0Addr == ADDR_EPC) begin
            epc <= bus.CP0In;
        end
    end

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) timer (
        .clk       (clk),
        .reset     (reset),
        .countWe   (mtc0 && bus.CP0Addr == ADDR_COUNT),
        .compareWe (mtc0 && bus.CP0Addr == ADDR_COMPARE),
        .wdata     (bus.CP0In),
        .count     (count),
        .compare   (compare),
        .ti        (ti)
    );

    always_comb begin
        causeVal                                = 32'd0;
        causeVal[CAUSE_BD]                      = causeBd;
        causeVal[CAUSE_TI]                      = ti;
        causeVal[CAUSE_IP_LSB +: NUM_HWINT]     = causeIpHw;
        causeVal[CAUSE_IPSW_LSB +: 2]           = causeIpSw;
        causeVal[CAUSE_EXC_LSB +: 5]            = causeExc;
    end

    always_comb begin
        readData = 32'd0;
        case (bus.CP0Addr)
            ADDR_BADVADDR: readData = badVAddr;
            ADDR_COUNT:    readData = count;
            ADDR_COMPARE:  readData = compare;
            ADDR_SR:       readData = sr;
            ADDR_CAUSE:    readData = causeVal;
            ADDR_EPC:      readData = epc;
            ADDR_PRID:     readData = PRID_VAL;
            default:       readData = 32'd0;
        endcase
    end

    assign bus.CP0Out   = readData;
    assign bus.EPCOut   = epcNext;
    assign bus.Req      = req;
    assign bus.TimerIrq = ti;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed scenarios followed by randomized traffic, all checked against an
// architectural model of CP0 held in plain variables.
module tb_cp0_ctrl;

    localparam int NHW = 6;
    localparam int DIV = 1;

    logic clk = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    cp0_ctrl_if #(.NUM_HWINT(NHW)) bus();

    cp0_ctrl #(
        .NUM_HWINT (NHW),
        .TIMER_EN  (1'b1),
        .COUNT_DIV (DIV),
        .PRID_VAL  (32'h0000_4C01)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mSr, mEpc, mBad, mCount, mCompare;
    logic        mBd, mTi;
    logic [4:0]  mExc;
    logic [1:0]  mIpSw;
    logic [5:0]  mIp;
    int          mPre;

    task automatic modelReset();
        mSr = 0; mEpc = 0; mBad = 0; mCount = 0; mCompare = 32'hFFFF_FFFF;
        mBd = 0; mTi = 0; mExc = 0; mIpSw = 0; mIp = 0; mPre = 0;
    endtask

    function automatic logic [5:0] effLines();
        return bus.HWInt | {mTi, 5'b0};
    endfunction

    function automatic logic takeInt();
        return (|(effLines() & mSr[15:10])) && mSr[0] && !mSr[1];
    endfunction

    function automatic logic takeExc();
        return (bus.ExcCodeIn != 5'd0) && !mSr[1];
    endfunction

    function automatic logic [31:0] expEpcOut();
        if (takeInt() || takeExc()) return bus.BDin ? bus.VPC - 32'd4 : bus.VPC;
        return mEpc;
    endfunction

    function automatic logic [31:0] expRead(input logic [4:0] a);
        logic [31:0] c;
        c = 32'd0;
        c[31] = mBd; c[30] = mTi; c[15:10] = mIp; c[9:8] = mIpSw; c[6:2] = mExc;
        case (a)
            5'd8:    return mBad;
            5'd9:    return mCount;
            5'd11:   return mCompare;
            5'd12:   return mSr;
            5'd13:   return c;
            5'd14:   return mEpc;
            5'd15:   return 32'h0000_4C01;
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic modelStep();
        logic [5:0]  lines;
        logic        iR, rq, wr, nTi;
        logic [31:0] epcO;
        lines = effLines();
        iR    = takeInt();
        rq    = iR || takeExc();
        epcO  = expEpcOut();
        wr    = bus.en && !rq;
        nTi   = (wr && bus.CP0Addr == 5'd11) ? 1'b0 : ((mCount == mCompare) ? 1'b1 : mTi);
        if (rq) begin
            mExc = iR ? 5'd0 : bus.ExcCodeIn;
            mSr[1] = 1'b1;
            mEpc = epcO;
            mBd = bus.BDin;
            if (!iR && (bus.ExcCodeIn == 5'd4 || bus.ExcCodeIn == 5'd5)) mBad = bus.BadVAddrIn;
        end else begin
            if (wr && bus.CP0Addr == 5'd12) mSr = bus.CP0In;
            if (wr && bus.CP0Addr == 5'd13) begin
                mBd = bus.CP0In[31]; mExc = bus.CP0In[6:2]; mIpSw = bus.CP0In[9:8];
            end
            if (wr && bus.CP0Addr == 5'd14) mEpc = bus.CP0In;
            if (wr && bus.CP0Addr == 5'd11) mCompare = bus.CP0In;
            if (bus.EXLClr) mSr[1] = 1'b0;
        end
        if (wr && bus.CP0Addr == 5'd9) begin
            mCount = bus.CP0In; mPre = 0;
        end else if (mPre == DIV - 1) begin
            mCount = mCount + 32'd1; mPre = 0;
        end else begin
            mPre = mPre + 1;
        end
        mIp = lines;
        mTi = nTi;
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [4:0] addr, input logic [31:0] data,
                                 input logic [31:0] vpc, input logic bd, input logic [4:0] exc,
                                 input logic [31:0] bad, input logic [5:0] hw, input logic exlclr);
        bus.en = en; bus.CP0Addr = addr; bus.CP0In = data; bus.VPC = vpc; bus.BDin = bd;
        bus.ExcCodeIn = exc; bus.BadVAddrIn = bad; bus.HWInt = hw; bus.EXLClr = exlclr;
        #1;
    endtask

    task automatic checkOutput(input string tag);
        check32({tag, " Req"}, 32'(bus.Req), 32'(takeInt() || takeExc()));
        check32({tag, " EPCOut"}, bus.EPCOut, expEpcOut());
        check32({tag, " TimerIrq"}, 32'(bus.TimerIrq), 32'(mTi));
        check32({tag, " CP0Out"}, bus.CP0Out, expRead(bus.CP0Addr));
        modelStep();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [4:0]  addrs [8];
        logic [4:0]  excs  [4];
        logic [4:0]  a;
        logic [31:0] d;
        addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
        excs  = '{5'd4, 5'd5, 5'd10, 5'd12};

        reset = 1'b1;
        modelReset();
        applyStimulus(0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        applyStimulus(0, 5'd11, 0, 0, 0, 0, 0, 0, 0);
        check32("reset Compare", bus.CP0Out, 32'hFFFF_FFFF);
        check32("reset Req", 32'(bus.Req), 32'd0);
        checkOutput("reset");

        $display("[TB] interrupt in delay slot");
        applyStimulus(1, 5'd12, 32'h0000_0401, 0, 0, 0, 0, 0, 0);
        checkOutput("t2 wrSR");
        applyStimulus(0, 5'd14, 0, 32'h3008, 1, 0, 0, 6'h01, 0);
        check32("t2 Req", 32'(bus.Req), 32'd1);
        check32("t2 EPCOut", bus.EPCOut, 32'h3004);
        checkOutput("t2 take");
        applyStimulus(0, 5'd14, 0, 32'h3008, 1, 0, 0, 6'h01, 0);
        check32("t2 Req after", 32'(bus.Req), 32'd0);
        check32("t2 EPC", bus.CP0Out, 32'h3004);
        checkOutput("t2 epc");
        applyStimulus(0, 5'd13, 0, 32'h3008, 1, 0, 0, 6'h01, 0);
        check32("t2 Cause", bus.CP0Out, 32'h8000_0400);
        checkOutput("t2 cause");

        $display("[TB] address error drops mtc0");
        applyStimulus(0, 5'd12, 0, 0, 0, 0, 0, 0, 1);
        check32("t3 SR before", bus.CP0Out, 32'h0000_0403);
        checkOutput("t3 eret");
        applyStimulus(1, 5'd12, 0, 32'h4000, 0, 5'd4, 32'h1001, 0, 0);
        check32("t3 Req", 32'(bus.Req), 32'd1);
        checkOutput("t3 take");
        applyStimulus(0, 5'd8, 0, 0, 0, 0, 0, 0, 0);
        check32("t3 BadVAddr", bus.CP0Out, 32'h1001);
        checkOutput("t3 bad");
        applyStimulus(0, 5'd13, 0, 0, 0, 0, 0, 0, 0);
        check32("t3 Cause", bus.CP0Out, 32'h0000_0010);
        checkOutput("t3 cause");
        applyStimulus(0, 5'd12, 0, 0, 0, 0, 0, 0, 1);
        check32("t3 SR kept", bus.CP0Out, 32'h0000_0403);
        checkOutput("t3 sr");

        $display("[TB] timer interrupt");
        applyStimulus(1, 5'd12, 32'h0000_8001, 0, 0, 0, 0, 0, 0);
        checkOutput("t4 wrSR");
        applyStimulus(1, 5'd11, 32'd10, 0, 0, 0, 0, 0, 0);
        checkOutput("t4 wrCmp");
        applyStimulus(1, 5'd9, 32'd0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4 wrCnt");
        for (int k = 0; k <= 10; k++) begin
            applyStimulus(0, 5'd9, 0, 32'h5000, 0, 0, 0, 0, 0);
            check32("t4 Count", bus.CP0Out, 32'(k));
            check32("t4 TI low", 32'(bus.TimerIrq), 32'd0);
            checkOutput("t4 run");
        end
        applyStimulus(0, 5'd13, 0, 32'h5000, 0, 0, 0, 0, 0);
        check32("t4 TI high", 32'(bus.TimerIrq), 32'd1);
        check32("t4 Req", 32'(bus.Req), 32'd1);
        checkOutput("t4 take");
        applyStimulus(1, 5'd11, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
        check32("t4 TI sticky", 32'(bus.TimerIrq), 32'd1);
        checkOutput("t4 clr");
        applyStimulus(0, 5'd13, 0, 0, 0, 0, 0, 0, 0);
        check32("t4 TI cleared", 32'(bus.TimerIrq), 32'd0);
        checkOutput("t4 after");

        $display("[TB] eret against pending exception");
        applyStimulus(0, 5'd12, 0, 32'h6000, 0, 5'd12, 0, 0, 1);
        check32("t5 Req masked", 32'(bus.Req), 32'd0);
        checkOutput("t5 eret");
        applyStimulus(0, 5'd13, 0, 32'h6000, 0, 5'd12, 0, 0, 0);
        check32("t5 Req", 32'(bus.Req), 32'd1);
        check32("t5 EPCOut", bus.EPCOut, 32'h6000);
        checkOutput("t5 take");
        applyStimulus(0, 5'd13, 0, 0, 0, 0, 0, 0, 0);
        check32("t5 Cause", bus.CP0Out, 32'h0000_0030);
        checkOutput("t5 cause");

        $display("[TB] read-only and unmapped");
        applyStimulus(1, 5'd15, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6 wrPRId");
        applyStimulus(0, 5'd15, 0, 0, 0, 0, 0, 0, 0);
        check32("t6 PRId", bus.CP0Out, 32'h0000_4C01);
        checkOutput("t6 prid");
        applyStimulus(0, 5'd3, 0, 0, 0, 0, 0, 0, 0);
        check32("t6 unmapped", bus.CP0Out, 32'd0);
        checkOutput("t6 unmapped");

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            a = addrs[$urandom_range(0, 7)];
            d = $urandom;
            if (a == 5'd11 && $urandom_range(0, 1) == 1) d = mCount + 32'($urandom_range(0, 4));
            if (a == 5'd9 && $urandom_range(0, 3) == 0) d = 32'hFFFF_FFFD;
            applyStimulus(1'($urandom_range(0, 1)), a, d, $urandom, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 5) == 0) ? excs[$urandom_range(0, 3)] : 5'd0,
                          $urandom, ($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'd0,
                          1'($urandom_range(0, 3) == 0));
            checkOutput("rand");
        end

        $display("[TB] asynchronous reset mid-run");
        applyStimulus(1, 5'd12, 32'h0000_0002, 0, 0, 0, 0, 0, 0);
        checkOutput("t1 wrSR a");
        applyStimulus(1, 5'd12, 32'h0000_0002, 0, 0, 0, 0, 0, 0);
        checkOutput("t1 wrSR b");
        applyStimulus(1, 5'd9, 32'd5, 0, 0, 0, 0, 0, 0);
        checkOutput("t1 wrCnt");
        applyStimulus(0, 5'd9, 0, 32'h7000, 0, 0, 0, 0, 0);
        check32("t1 Count pre", bus.CP0Out, 32'd5);
        applyStimulus(0, 5'd12, 0, 32'h7000, 0, 0, 0, 0, 0);
        check32("t1 SR pre", bus.CP0Out, 32'h0000_0002);
        reset = 1'b1;
        modelReset();
        #1;
        check32("t1 Req", 32'(bus.Req), 32'd0);
        check32("t1 EPCOut", bus.EPCOut, 32'd0);
        check32("t1 TimerIrq", 32'(bus.TimerIrq), 32'd0);
        for (int j = 0; j < 7; j++) begin
            bus.CP0Addr = addrs[j];
            #1;
            check32("t1 reg", bus.CP0Out, expRead(addrs[j]));
        end
        bus.CP0Addr = 5'd11;
        #1;
        check32("t1 Compare", bus.CP0Out, 32'hFFFF_FFFF);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(0, 5'd9, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1 after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
